// File: rtl/tpi_hs_bank.sv
// Bank of NPORTS bidirectional ports with per-bit DDR behind a synchronous register bus,
// plus an automatic four-phase DAV/ACK handshake engine with a wait-state timeout.
module tpi_hs_bank #(
  parameter int unsigned NPORTS       = 3,
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned AW           = 3,
  parameter int unsigned HS_DATA_PORT = 0,
  parameter int unsigned HS_CTRL_PORT = 2,
  parameter int unsigned HS_DAV_BIT   = 6,
  parameter int unsigned HS_ACK_BIT   = 7,
  parameter int unsigned TIMEOUT      = 1023
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cs,
  input  logic                    we,
  input  logic [AW-1:0]           addr,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata,
  output logic                    rvalid,
  input  logic [NPORTS*WIDTH-1:0] pins_in,
  output logic [NPORTS*WIDTH-1:0] pins_out,
  output logic [NPORTS*WIDTH-1:0] pins_oe,
  output logic                    irq
);

  localparam int unsigned NB       = NPORTS * WIDTH;
  localparam int unsigned CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned CtrlAddr = 2 * NPORTS;
  localparam int unsigned StatAddr = 2 * NPORTS + 1;
  localparam int unsigned DavIdx   = HS_CTRL_PORT * WIDTH + HS_DAV_BIT;
  localparam int unsigned AckIdx   = HS_CTRL_PORT * WIDTH + HS_ACK_BIT;
  localparam logic [CW-1:0] TimeoutCnt = CW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StWaitAckHi, StWaitAckLo} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] latch_q [NPORTS];
  logic [WIDTH-1:0] latch_d [NPORTS];
  logic [WIDTH-1:0] ddr_q   [NPORTS];
  logic [WIDTH-1:0] ddr_d   [NPORTS];
  logic [1:0]       ctrl_q, ctrl_d;
  logic             done_q, done_d;
  logic             to_q, to_d;
  logic             ovr_q, ovr_d;
  logic [NB-1:0]    sync_q, pin_s;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q;

  int unsigned addr_int;
  logic        wr, rd, data_wr, ctrl_wr, stat_rd;
  logic        auto_d, ack_s;
  logic        set_done, set_to;
  logic        dav, busy;

  assign addr_int = 32'(addr);
  assign wr       = cs & we;
  assign rd       = cs & ~we;
  assign data_wr  = wr && (addr_int == HS_DATA_PORT);
  assign ctrl_wr  = wr && (addr_int == CtrlAddr);
  assign stat_rd  = rd && (addr_int == StatAddr);
  assign ack_s    = pin_s[AckIdx];
  // Clearing AUTO aborts on the same edge that stores the new CTRL value.
  assign auto_d   = ctrl_wr ? wdata[0] : ctrl_q[0];

  // Two-flop input synchroniser.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      pin_s  <= '0;
    end else begin
      sync_q <= pins_in;
      pin_s  <= sync_q;
    end
  end

  always_comb begin
    latch_d = latch_q;
    ddr_d   = ddr_q;
    ctrl_d  = ctrl_q;
    if (wr) begin
      for (int unsigned p = 0; p < NPORTS; p++) begin
        if (addr_int == p) latch_d[p] = wdata;
        if (addr_int == NPORTS + p) ddr_d[p] = wdata;
      end
      if (addr_int == CtrlAddr) ctrl_d = wdata[1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      latch_q <= '{default: '0};
      ddr_q   <= '{default: '0};
      ctrl_q  <= '0;
    end else begin
      latch_q <= latch_d;
      ddr_q   <= ddr_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    rdata_d = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      if (addr_int == p) begin
        rdata_d = (ddr_q[p] & latch_q[p]) | (~ddr_q[p] & pin_s[p*WIDTH +: WIDTH]);
      end
      if (addr_int == NPORTS + p) rdata_d = ddr_q[p];
    end
    if (addr_int == CtrlAddr) rdata_d = WIDTH'(ctrl_q);
    if (addr_int == StatAddr) rdata_d = WIDTH'({ovr_q, to_q, done_q, busy});
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd;
      if (rd) rdata_q <= rdata_d;
    end
  end

  // A flag-set event on the clearing STATUS read wins over the clear.
  always_comb begin
    done_d = (done_q & ~stat_rd) | set_done;
    to_d   = (to_q & ~stat_rd) | set_to;
    ovr_d  = (ovr_q & ~stat_rd) | (data_wr & busy);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      done_q <= 1'b0;
      to_q   <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      done_q <= done_d;
      to_q   <= to_d;
      ovr_q  <= ovr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    set_done = 1'b0;
    set_to   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = cnt_q;
        if (data_wr && ctrl_q[0]) begin
          state_d = StWaitAckHi;
          cnt_d   = '0;
        end
      end
      StWaitAckHi: begin
        if (!auto_d) begin
          state_d = StIdle;
        end else if (ack_s) begin
          state_d = StWaitAckLo;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutCnt) begin
          state_d = StIdle;
          set_to  = 1'b1;
        end
      end
      StWaitAckLo: begin
        if (!auto_d) begin
          state_d = StIdle;
        end else if (!ack_s) begin
          state_d  = StIdle;
          set_done = 1'b1;
        end else if (cnt_q == TimeoutCnt) begin
          state_d = StIdle;
          set_to  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dav  = (state_q == StWaitAckHi);
    busy = (state_q != StIdle);
  end

  // With AUTO set the engine owns the DAV pin regardless of the host's latch and DDR.
  always_comb begin
    pins_out = '0;
    pins_oe  = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      pins_out[p*WIDTH +: WIDTH] = latch_q[p];
      pins_oe[p*WIDTH +: WIDTH]  = ddr_q[p];
    end
    if (ctrl_q[0]) begin
      pins_out[DavIdx] = dav;
      pins_oe[DavIdx]  = 1'b1;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign irq    = (done_q | to_q) & ctrl_q[1];

endmodule
